// File: rtl/core_preempt_unit.sv
// core_preempt_unit: executes halt, jump and load/store preempt requests from
// the decoder slots. It owns the data-memory port, the stdin/stdout port at
// 0xFF, the PC redirect and the load write-back.
module core_preempt_unit #(
  parameter int unsigned N_SLOTS = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [N_SLOTS-1:0]      req_lsu_en_i,
  input  logic [N_SLOTS-1:0]      req_lsu_wen_i,
  input  logic [N_SLOTS-1:0]      req_lsu_kind_i,
  input  logic [N_SLOTS-1:0]      req_jump_en_i,
  input  logic [N_SLOTS-1:0]      req_jump_kind_i,
  input  logic [N_SLOTS-1:0]      req_halt_i,
  input  logic [16*N_SLOTS-1:0]   slot_instr_i,
  input  logic [16*N_SLOTS-1:0]   slot_rd_data_i,
  input  logic [16*N_SLOTS-1:0]   slot_rt_data_i,
  output logic                    busy_o,
  output logic                    pc_wen_o,
  output logic [7:0]              pc_o,
  output logic                    wb_en_o,
  output logic [3:0]              wb_addr_o,
  output logic [15:0]             wb_data_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [7:0]              mem_addr_o,
  output logic [15:0]             mem_wdata_o,
  input  logic                    mem_gnt_i,
  input  logic                    mem_rvalid_i,
  input  logic [15:0]             mem_rdata_i,
  input  logic                    stdin_valid_i,
  input  logic [15:0]             stdin_data_i,
  output logic                    stdin_ready_o,
  output logic                    stdout_valid_o,
  output logic [15:0]             stdout_data_o,
  input  logic                    stdout_ready_i,
  output logic                    halted_o,
  output logic                    err_o
);

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 8;
  localparam int unsigned RW = 4;
  localparam logic [AW-1:0] IO_ADDR = 8'hFF;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MEM_REQ  = 3'd1,
    MEM_WAIT = 3'd2,
    IO_IN    = 3'd3,
    IO_OUT   = 3'd4,
    WB       = 3'd5,
    HALTED   = 3'd6
  } state_e;

  state_e state_q, state_d;

  logic          busy_q, busy_d;
  logic          pc_wen_q, pc_wen_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          wb_en_q, wb_en_d;
  logic [RW-1:0] wb_addr_q, wb_addr_d;
  logic [DW-1:0] wb_data_q, wb_data_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          stdin_ready_q, stdin_ready_d;
  logic          stdout_valid_q, stdout_valid_d;
  logic [DW-1:0] stdout_data_q, stdout_data_d;
  logic          halted_q, halted_d;
  logic          err_q, err_d;
  logic [RW-1:0] rd_q, rd_d;

  logic [N_SLOTS-1:0] slot_active;
  logic               any_active;
  logic               multi_active;
  logic               sel_halt;
  logic               sel_jump;
  logic               sel_jkind;
  logic               sel_wen;
  logic               sel_lkind;
  logic [RW-1:0]      sel_rd;
  logic [AW-1:0]      sel_addr;
  logic [DW-1:0]      sel_rd_data;
  logic [AW-1:0]      sel_rt_lo;
  logic [AW-1:0]      eff_addr;
  logic               unused_bits;

  assign slot_active = req_lsu_en_i | req_jump_en_i | req_halt_i;
  assign any_active  = |slot_active;
  assign eff_addr    = sel_lkind ? sel_addr : sel_rt_lo;

  // Pick the lowest-index active slot and flag when more than one is active
  always_comb begin
    multi_active = 1'b0;
    sel_halt     = 1'b0;
    sel_jump     = 1'b0;
    sel_jkind    = 1'b0;
    sel_wen      = 1'b0;
    sel_lkind    = 1'b0;
    sel_rd       = '0;
    sel_addr     = '0;
    sel_rd_data  = '0;
    sel_rt_lo    = '0;
    for (int k = N_SLOTS - 1; k >= 0; k--) begin
      if (slot_active[k]) begin
        if (|(slot_active & ((N_SLOTS)'(1) << k) - (N_SLOTS)'(1))) multi_active = 1'b1;
        sel_halt    = req_halt_i[k];
        sel_jump    = req_jump_en_i[k];
        sel_jkind   = req_jump_kind_i[k];
        sel_wen     = req_lsu_wen_i[k];
        sel_lkind   = req_lsu_kind_i[k];
        sel_rd      = slot_instr_i[DW*k+8 +: RW];
        sel_addr    = slot_instr_i[DW*k +: AW];
        sel_rd_data = slot_rd_data_i[DW*k +: DW];
        sel_rt_lo   = slot_rt_data_i[DW*k +: AW];
      end
    end
  end

  // Fold instruction opcode bits and upper R[t] bytes that this unit never uses
  always_comb begin
    unused_bits = 1'b0;
    for (int k = 0; k < N_SLOTS; k++) begin
      unused_bits = unused_bits ^ (^{slot_instr_i[DW*k+12 +: 4], slot_rt_data_i[DW*k+8 +: 8]});
    end
  end

  // Next-state and next-output logic; strobes are derived from the next state
  always_comb begin
    state_d       = state_q;
    err_d         = err_q;
    halted_d      = halted_q;
    pc_wen_d      = 1'b0;
    pc_d          = pc_q;
    wb_addr_d     = wb_addr_q;
    wb_data_d     = wb_data_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    stdout_data_d = stdout_data_q;
    rd_d          = rd_q;

    unique case (state_q)
      IDLE: begin
        if (any_active) begin
          if (multi_active) err_d = 1'b1;
          if (sel_halt) begin
            state_d  = HALTED;
            halted_d = 1'b1;
          end else if (sel_jump) begin
            pc_wen_d = 1'b1;
            pc_d     = sel_jkind ? sel_addr : sel_rd_data[AW-1:0];
          end else begin
            rd_d = sel_rd;
            if (eff_addr == IO_ADDR) begin
              if (sel_wen) begin
                state_d       = IO_OUT;
                stdout_data_d = sel_rd_data;
              end else begin
                state_d = IO_IN;
              end
            end else begin
              state_d     = MEM_REQ;
              mem_addr_d  = eff_addr;
              mem_we_d    = sel_wen;
              mem_wdata_d = sel_rd_data;
            end
          end
        end
      end
      MEM_REQ: begin
        if (mem_gnt_i) state_d = mem_we_q ? IDLE : MEM_WAIT;
      end
      MEM_WAIT: begin
        if (mem_rvalid_i) begin
          state_d   = WB;
          wb_data_d = mem_rdata_i;
        end
      end
      IO_IN: begin
        if (stdin_valid_i) begin
          state_d   = WB;
          wb_data_d = stdin_data_i;
        end
      end
      IO_OUT: begin
        if (stdout_ready_i) state_d = IDLE;
      end
      WB: begin
        state_d = IDLE;
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if ((state_q != IDLE) && (state_q != HALTED) && any_active) err_d = 1'b1;

    if (state_d == WB) wb_addr_d = rd_q;
    wb_en_d        = (state_d == WB) && (rd_q != '0);
    busy_d         = (state_d != IDLE) && (state_d != HALTED);
    mem_req_d      = (state_d == MEM_REQ);
    stdin_ready_d  = (state_d == IO_IN);
    stdout_valid_d = (state_d == IO_OUT);
  end

  // State and output registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      busy_q         <= 1'b0;
      pc_wen_q       <= 1'b0;
      pc_q           <= '0;
      wb_en_q        <= 1'b0;
      wb_addr_q      <= '0;
      wb_data_q      <= '0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      stdin_ready_q  <= 1'b0;
      stdout_valid_q <= 1'b0;
      stdout_data_q  <= '0;
      halted_q       <= 1'b0;
      err_q          <= 1'b0;
      rd_q           <= '0;
    end else begin
      state_q        <= state_d;
      busy_q         <= busy_d;
      pc_wen_q       <= pc_wen_d;
      pc_q           <= pc_d;
      wb_en_q        <= wb_en_d;
      wb_addr_q      <= wb_addr_d;
      wb_data_q      <= wb_data_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      stdin_ready_q  <= stdin_ready_d;
      stdout_valid_q <= stdout_valid_d;
      stdout_data_q  <= stdout_data_d;
      halted_q       <= halted_d;
      err_q          <= err_d;
      rd_q           <= rd_d;
    end
  end

  assign busy_o         = busy_q;
  assign pc_wen_o       = pc_wen_q;
  assign pc_o           = pc_q;
  assign wb_en_o        = wb_en_q;
  assign wb_addr_o      = wb_addr_q;
  assign wb_data_o      = wb_data_q;
  assign mem_req_o      = mem_req_q;
  assign mem_we_o       = mem_we_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_wdata_o    = mem_wdata_q;
  assign stdin_ready_o  = stdin_ready_q;
  assign stdout_valid_o = stdout_valid_q;
  assign stdout_data_o  = stdout_data_q;
  assign halted_o       = halted_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_core_preempt_unit.sv
// Self-checking bench for core_preempt_unit: single-request vectors from a
// table plus hand-written multi-cycle sequences.
module tb_core_preempt_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  lsu_en, lsu_wen, lsu_kind, jump_en, jump_kind, halt;
  logic [63:0] instr, rdd, rtd;
  logic        busy, pc_wen, wb_en, mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [7:0]  pc, mem_addr;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data, mem_wdata, mem_rdata, stdin_data, stdout_data;
  logic        stdin_valid, stdin_ready, stdout_valid, stdout_ready, halted, err;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  core_preempt_unit #(.N_SLOTS(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_lsu_en_i(lsu_en), .req_lsu_wen_i(lsu_wen), .req_lsu_kind_i(lsu_kind),
    .req_jump_en_i(jump_en), .req_jump_kind_i(jump_kind), .req_halt_i(halt),
    .slot_instr_i(instr), .slot_rd_data_i(rdd), .slot_rt_data_i(rtd),
    .busy_o(busy), .pc_wen_o(pc_wen), .pc_o(pc),
    .wb_en_o(wb_en), .wb_addr_o(wb_addr), .wb_data_o(wb_data),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .stdin_valid_i(stdin_valid), .stdin_data_i(stdin_data), .stdin_ready_o(stdin_ready),
    .stdout_valid_o(stdout_valid), .stdout_data_o(stdout_data), .stdout_ready_i(stdout_ready),
    .halted_o(halted), .err_o(err)
  );

  wire [76:0] all_outs = {busy, pc_wen, pc, wb_en, wb_addr, wb_data, mem_req, mem_we,
                          mem_addr, mem_wdata, stdin_ready, stdout_valid, stdout_data,
                          halted, err};

  typedef struct packed {
    logic [3:0]  lsu_en, wen, lkind, jen, jkind;
    logic [63:0] instr, rdd, rtd;
    logic        e_pcw;
    logic [7:0]  e_pc;
    logic        e_busy, e_req;
    logic [7:0]  e_addr;
    logic        e_we;
    logic [15:0] e_wdata;
    logic        e_err;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic clear_reqs();
    lsu_en = '0; lsu_wen = '0; lsu_kind = '0;
    jump_en = '0; jump_kind = '0; halt = '0;
    instr = '0; rdd = '0; rtd = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  int cnt, bcnt, rcnt, wcnt;

  initial begin
    //                lsu     wen     lkind   jen     jkind   instr                  rdd                    rtd                    pcw pc    busy req addr  we  wdata     err
    vecs[0] = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 64'h0000_0000_0000_0010, 64'h0, 64'h0, 1'b1, 8'h10, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0};
    vecs[1] = '{4'h0, 4'h0, 4'h0, 4'h2, 4'h0, 64'h0, 64'h0000_0000_AB37_0000, 64'h0, 1'b1, 8'h37, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0};
    vecs[2] = '{4'h0, 4'h0, 4'h0, 4'h8, 4'h8, 64'h12C3_0000_0000_0000, 64'h0, 64'h0, 1'b1, 8'hC3, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0};
    vecs[3] = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 64'h0000_0000_0000_0155, 64'h0000_0000_0000_5A5A, 64'h0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h55, 1'b1, 16'h5A5A, 1'b0};
    vecs[4] = '{4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 64'h0000_0000_0300_0000, 64'h0000_0000_C0DE_0000, 64'h0000_0000_1277_0000, 1'b0, 8'h00, 1'b1, 1'b1, 8'h77, 1'b1, 16'hC0DE, 1'b0};
    vecs[5] = '{4'h4, 4'h0, 4'h4, 4'h4, 4'h4, 64'h0000_0033_0000_0000, 64'h0, 64'h0, 1'b1, 8'h33, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0};
    vecs[6] = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 64'h0000_0000_0000_00FE, 64'h0000_0000_0000_0F0F, 64'h0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hFE, 1'b1, 16'h0F0F, 1'b0};
    vecs[7] = '{4'h0, 4'h0, 4'h0, 4'hA, 4'hA, 64'h0099_0000_0020_0000, 64'h0, 64'h0, 1'b1, 8'h20, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b1};

    clear_reqs();
    rst_n = 1'b0; mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
    stdin_valid = 1'b0; stdin_data = '0; stdout_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", 128'(all_outs), 128'h0);
    rst_n = 1'b1;

    // Single-request vectors, each from IDLE with an always-granting memory
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      lsu_en = vecs[i].lsu_en; lsu_wen = vecs[i].wen; lsu_kind = vecs[i].lkind;
      jump_en = vecs[i].jen; jump_kind = vecs[i].jkind;
      instr = vecs[i].instr; rdd = vecs[i].rdd; rtd = vecs[i].rtd;
      @(negedge clk);
      clear_reqs();
      check($sformatf("v%0d_pc_wen", i), 128'(pc_wen), 128'(vecs[i].e_pcw));
      check($sformatf("v%0d_busy", i), 128'(busy), 128'(vecs[i].e_busy));
      check($sformatf("v%0d_mem_req", i), 128'(mem_req), 128'(vecs[i].e_req));
      check($sformatf("v%0d_err", i), 128'(err), 128'(vecs[i].e_err));
      if (vecs[i].e_pcw) check($sformatf("v%0d_pc", i), 128'(pc), 128'(vecs[i].e_pc));
      if (vecs[i].e_req) begin
        check($sformatf("v%0d_addr", i), 128'(mem_addr), 128'(vecs[i].e_addr));
        check($sformatf("v%0d_we", i), 128'(mem_we), 128'(vecs[i].e_we));
        check($sformatf("v%0d_wdata", i), 128'(mem_wdata), 128'(vecs[i].e_wdata));
      end
      @(negedge clk);
      check($sformatf("v%0d_pc_wen_drop", i), 128'(pc_wen), 128'h0);
      @(negedge clk);
      check($sformatf("v%0d_drain_busy", i), 128'(busy), 128'h0);
    end

    // Direct load with minimum-latency memory
    do_reset();
    mem_gnt = 1'b1;
    @(negedge clk);
    lsu_en = 4'h1; lsu_kind = 4'h1; instr = 64'h8A42;
    bcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy) bcnt++;
      if (i == 0) begin
        clear_reqs();
        check("ld_req", 128'(mem_req), 128'h1);
        check("ld_addr", 128'(mem_addr), 128'h42);
        check("ld_we", 128'(mem_we), 128'h0);
      end
      if (i == 1) begin
        check("ld_req_drop", 128'(mem_req), 128'h0);
        mem_rvalid = 1'b1; mem_rdata = 16'hBEEF;
      end
      if (i == 2) begin
        mem_rvalid = 1'b0;
        check("ld_wb_en", 128'(wb_en), 128'h1);
        check("ld_wb_addr", 128'(wb_addr), 128'hA);
        check("ld_wb_data", 128'(wb_data), 128'hBEEF);
      end
      if (i == 3) check("ld_wb_en_drop", 128'(wb_en), 128'h0);
    end
    check("ld_busy_cycles", 128'(bcnt), 128'd3);

    // Indirect store to stdout with a slow consumer
    @(negedge clk);
    lsu_en = 4'h4; lsu_wen = 4'h4; lsu_kind = 4'h0;
    instr = 64'h0000_B305_0000_0000; rtd = 64'h0000_00FF_0000_0000; rdd = 64'h0000_1234_0000_0000;
    stdout_ready = 1'b0;
    cnt = 0; rcnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) clear_reqs();
      if (stdout_valid) begin
        cnt++;
        check($sformatf("st_io_data%0d", i), 128'(stdout_data), 128'h1234);
      end
      if (mem_req) rcnt++;
      if (i == 3) stdout_ready = 1'b1;
      if (i == 4) stdout_ready = 1'b0;
    end
    check("st_io_valid_cycles", 128'(cnt), 128'd4);
    check("st_io_no_mem", 128'(rcnt), 128'd0);
    check("st_io_idle", 128'(busy), 128'h0);

    // Halt, then load requests must be ignored until reset
    @(negedge clk);
    halt = 4'h1;
    @(negedge clk);
    clear_reqs();
    check("halt_set", 128'(halted), 128'h1);
    check("halt_not_busy", 128'(busy), 128'h0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      lsu_en = 4'h1; lsu_kind = 4'h1; instr = 64'h8A42; mem_rvalid = 1'b1;
      @(negedge clk);
      if (mem_req || wb_en || busy || pc_wen || stdin_ready || stdout_valid) cnt++;
    end
    clear_reqs(); mem_rvalid = 1'b0;
    check("halt_no_activity", 128'(cnt), 128'd0);
    check("halt_sticky", 128'(halted), 128'h1);
    check("halt_no_err", 128'(err), 128'h0);
    do_reset();
    check("halt_cleared", 128'(halted), 128'h0);

    // Load to R0 from stdin: handshake completes, no write-back
    @(negedge clk);
    lsu_en = 4'h2; lsu_kind = 4'h2; instr = 64'h0000_0000_00FF_0000; stdin_data = 16'h4321;
    rcnt = 0; wcnt = 0; bcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) clear_reqs();
      if (stdin_ready) rcnt++;
      if (wb_en) wcnt++;
      if (busy) bcnt++;
      if (i == 1) stdin_valid = 1'b1;
      if (i == 2) begin
        stdin_valid = 1'b0;
        check("in_r0_data", 128'(wb_data), 128'h4321);
      end
    end
    check("in_r0_ready_cycles", 128'(rcnt), 128'd2);
    check("in_r0_no_wb", 128'(wcnt), 128'd0);
    check("in_r0_busy_cycles", 128'(bcnt), 128'd3);

    // Two active slots: lowest wins and err is raised
    do_reset();
    mem_gnt = 1'b1;
    @(negedge clk);
    lsu_en = 4'h2; lsu_wen = 4'h2; lsu_kind = 4'h2; jump_en = 4'h8; jump_kind = 4'h8;
    instr = 64'h0099_0000_0120_0000; rdd = 64'h0000_0000_7777_0000;
    @(negedge clk);
    clear_reqs();
    check("multi_req", 128'(mem_req), 128'h1);
    check("multi_addr", 128'(mem_addr), 128'h20);
    check("multi_wdata", 128'(mem_wdata), 128'h7777);
    check("multi_no_jump", 128'(pc_wen), 128'h0);
    check("multi_err", 128'(err), 128'h1);
    @(negedge clk);

    // Request while busy, then reset during MEM_WAIT
    do_reset();
    mem_gnt = 1'b0;
    @(negedge clk);
    lsu_en = 4'h1; lsu_kind = 4'h1; instr = 64'h8A42;
    @(negedge clk);
    clear_reqs();
    check("busy_req_pre_err", 128'(err), 128'h0);
    jump_en = 4'h4; jump_kind = 4'h4; instr = 64'h0000_0050_0000_0000;
    @(negedge clk);
    clear_reqs();
    check("busy_req_err", 128'(err), 128'h1);
    check("busy_req_no_pc", 128'(pc_wen), 128'h0);
    check("busy_req_held", 128'(mem_req), 128'h1);
    mem_gnt = 1'b1;
    @(negedge clk);
    check("wait_busy", 128'(busy), 128'h1);
    check("wait_req_drop", 128'(mem_req), 128'h0);
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", 128'(all_outs), 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 16'hDEAD;
    cnt = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (wb_en || busy || mem_req) cnt++;
    end
    check("late_rvalid_ignored", 128'(cnt), 128'd0);
    check("late_rvalid_wb_data", 128'(wb_data), 128'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/core_preempt_unit.md
# core_preempt_unit

Executes the preempt requests raised by the core's decoder slots: loads, stores, jumps, branches and halt. It sits between the decode group and the architectural state. It owns the data-memory port, the stdin/stdout port at address 0xFF, the PC redirect, and the load write-back into the register file. It holds `busy_o` high while a memory or I/O access is in flight, so the decode group stalls until the access completes.

## Interface
- `N_SLOTS`, 4, number of decoder slots in the issue group
- `clk_i`  in  1  core clock
- `rst_ni`  in  1  reset, asynchronous, active-low
- `req_lsu_en_i`, `req_lsu_wen_i`, `req_lsu_kind_i`  in  N_SLOTS each  per-slot LSU request, write flag, and kind (1: direct address, 0: indirect via R[t])
- `req_jump_en_i`, `req_jump_kind_i`  in  N_SLOTS each  per-slot jump request and kind (1: direct address, 0: R[d])
- `req_halt_i`  in  N_SLOTS  per-slot halt request
- `slot_instr_i`  in  16*N_SLOTS  instruction word per slot; slot k is bits [16k+15:16k]
- `slot_rd_data_i`, `slot_rt_data_i`  in  16*N_SLOTS each  R[d] and R[t] values per slot
- `busy_o`  out  1  access in flight; issue must stall
- `pc_wen_o`  out  1  one-cycle PC redirect strobe
- `pc_o`  out  8  PC redirect target
- `wb_en_o`  out  1  one-cycle load write-back strobe
- `wb_addr_o`  out  4  write-back register index
- `wb_data_o`  out  16  write-back data
- `mem_req_o`  out  1  memory request
- `mem_we_o`  out  1  memory write enable
- `mem_addr_o`  out  8  memory address
- `mem_wdata_o`  out  16  memory write data
- `mem_gnt_i`  in  1  memory grant
- `mem_rvalid_i`  in  1  memory read-data valid
- `mem_rdata_i`  in  16  memory read data
- `stdin_valid_i`  in  1  stdin handshake valid
- `stdin_data_i`  in  16  stdin data
- `stdin_ready_o`  out  1  stdin handshake ready
- `stdout_valid_o`  out  1  stdout handshake valid
- `stdout_data_o`  out  16  stdout data
- `stdout_ready_i`  in  1  stdout handshake ready
- `halted_o`  out  1  core halted (sticky)
- `err_o`  out  1  protocol error (sticky)

## Operation
- **Selection.** A slot is active when any of its requests is set. The lowest-index active slot wins. If more than one slot is active, set `err_o`; losing requests are dropped.
- **Request priority within a slot.** Halt, then jump, then LSU.
- **Field decode.** `rd` = instr[11:8], `rt` = instr[3:0], `addr` = instr[7:0].
- **Effective address.** If lsu_kind=1, `addr`; otherwise R[t][7:0].
- **States.**
  - `IDLE`: accepts requests.
  - `MEM_REQ`: holds `mem_req_o` until `mem_gnt_i`.
  - `MEM_WAIT`: waits for `mem_rvalid_i`.
  - `IO_IN`: holds `stdin_ready_o` until `stdin_valid_i`.
  - `IO_OUT`: holds `stdout_valid_o` until `stdout_ready_i`.
  - `WB`: single-cycle write-back.
  - `HALTED`: terminal.
- **Halt (in IDLE).** Go to HALTED and set `halted_o`. Leave HALTED only by reset. All requests are ignored while halted.
- **Jump (in IDLE).** Next cycle: `pc_wen_o`=1 and `pc_o` = `addr` (kind 1) or R[d][7:0] (kind 0). Stay in IDLE; `busy_o` stays low.
- **LSU (in IDLE).**
  - Latch `rd`, the effective address, the write flag, and R[d] as store data.
  - Effective address 0xFF: load goes to IO_IN, store goes to IO_OUT.
  - Any other address goes to MEM_REQ with `mem_we_o` = write flag.
- **Store.** MEM_REQ+gnt → IDLE. IO_OUT+ready → IDLE. `stdout_data_o` = latched R[d].
- **Load.** MEM_REQ+gnt → MEM_WAIT; MEM_WAIT+rvalid → WB, capturing `mem_rdata_i`. IO_IN+valid → WB, capturing `stdin_data_i`.
- **WB.** `wb_en_o`=1 only if rd≠0; `wb_addr_o`=rd; `wb_data_o` = captured data. Then → IDLE.
- **Busy.** `busy_o`=1 in every state except IDLE and HALTED.
- **Requests outside IDLE.** Requests arriving while `busy_o`=1 are ignored and set `err_o`.
- **Stray memory responses.** `mem_rvalid_i` outside MEM_WAIT is ignored.
- **Output stability.** `mem_addr_o`, `mem_we_o`, `mem_wdata_o` and `stdout_data_o` are registered and hold stable while their valid or request signal is high.

## Timing
- **Reset values.** All outputs 0; state IDLE. Reset mid-access returns to IDLE immediately and drops any pending strobe.
- **Request capture.** Requests are sampled on the rising edge in IDLE.
- **Output latency.** `busy_o`, `mem_req_o`, `stdin_ready_o`, `stdout_valid_o` and `pc_wen_o` rise one cycle after that edge.
- **Minimum memory load.** Gnt and rvalid each on the first possible cycle: accept at T, req at T+1 with gnt, rvalid at T+2, `wb_en_o` at T+3, IDLE at T+4. `busy_o` is high T+1..T+3.
- **Minimum memory store.** Req and gnt at T+1; `busy_o` falls at T+2.
- **Handshake completion.** Handshakes complete on the edge where both sides are high. The cycle after, the handshake signal drops and the next state's outputs are presented.

## Test plan
- **Direct load.** Slot 0 issues lsu_en, kind=1, instr 0x8A42; memory grants immediately and returns rvalid the next cycle with 0xBEEF. Expect `mem_addr_o`=0x42 with `mem_we_o`=0, then `wb_en_o`=1, `wb_addr_o`=0xA, `wb_data_o`=0xBEEF. `busy_o` is high for exactly 3 cycles.
- **Indirect store to stdout.** Slot 2 issues lsu_en+wen, kind=0, instr 0xB305, R[t]=0x00FF, R[d]=0x1234; `stdout_ready_i` is held low for 3 cycles. Expect `stdout_valid_o` held for 4 cycles with data 0x1234, no `mem_req_o`, then IDLE.
- **Jump, both kinds.** Jump kind 1 with addr 0x10: `pc_wen_o` pulses 1 cycle with `pc_o`=0x10 and `busy_o` stays low. Jump kind 0 with R[d]=0xAB37: `pc_o`=0x37.
- **Halt then requests.** Halt is followed by load requests. Expect `halted_o` stays 1, no memory traffic, and no write-back until `rst_ni` is pulsed.
- **Load to R0 via stdin.** Load with rd=0 at address 0xFF; `stdin_valid_i` is given after 2 cycles. Expect the handshake to complete and `wb_en_o` to stay 0.
- **Errors and reset.** Slots 1 and 3 request simultaneously: slot 1 is served and `err_o`=1. Separately, assert `rst_ni` low during MEM_WAIT: expect all outputs 0 immediately, and a late `mem_rvalid_i` is ignored.
